// File: rtl/mips_dbg_pkg.sv
// Shared debug-path definitions: dump FSM state encoding and stream length helper.
package mips_dbg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_CSUM = 2'd2,
        ST_FIN  = 2'd3
    } dump_state_t;

    function automatic int total_bytes(input int data_width, input int num_regs);
        return (data_width * num_regs) / 8;
    endfunction

endpackage

// File: rtl/reg_dump_tx.sv
// Captures a coherent snapshot of the register bus on start and streams it out MSB-first as bytes.
// Optional trailing XOR checksum byte when REG_DUMP_CHECKSUM_EN is defined.
module reg_dump_tx
    import mips_dbg_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [DATA_WIDTH*NUM_REGS-1:0] registers,
    input  logic                           start,
    input  logic                           out_ready,
    output logic                           out_valid,
    output logic [7:0]                     out_data,
    output logic                           busy,
    output logic                           done
);

    localparam int SNAP_W      = DATA_WIDTH * NUM_REGS;
    localparam int TOTAL_BYTES = total_bytes(DATA_WIDTH, NUM_REGS);
    localparam int CNT_W       = (TOTAL_BYTES > 1) ? $clog2(TOTAL_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL_BYTES - 1);

    dump_state_t       state_r;
    dump_state_t       state_s;
    logic [SNAP_W-1:0] snap_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [7:0]        cur_byte_s;
    logic              xfer_s;
    logic              last_s;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [7:0]        csum_r;
`endif

    // Byte 0 sits in the top bits of the snapshot, so the index counts down from the MSB.
    assign cur_byte_s = snap_r[SNAP_W - 8 - 8 * int'(cnt_r) +: 8];
    assign xfer_s     = out_valid & out_ready;
    assign last_s     = (cnt_r == LAST_IDX);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_s = ST_SEND;
                else       state_s = ST_IDLE;
            end
            ST_SEND: begin
                if (xfer_s && last_s) begin
`ifdef REG_DUMP_CHECKSUM_EN
                    state_s = ST_CSUM;
`else
                    state_s = ST_FIN;
`endif
                end else begin
                    state_s = ST_SEND;
                end
            end
            ST_CSUM: begin
`ifdef REG_DUMP_CHECKSUM_EN
                if (xfer_s) state_s = ST_FIN;
                else        state_s = ST_CSUM;
`else
                state_s = ST_IDLE;
`endif
            end
            ST_FIN:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Snapshot capture, byte counter and running checksum; counter parks on the last index.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_r <= '0;
            cnt_r  <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
            csum_r <= 8'h00;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        snap_r <= registers;
                        cnt_r  <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
                        csum_r <= 8'h00;
`endif
                    end
                end
                ST_SEND: begin
                    if (xfer_s) begin
                        if (!last_s) cnt_r <= cnt_r + CNT_W'(1);
`ifdef REG_DUMP_CHECKSUM_EN
                        csum_r <= csum_r ^ cur_byte_s;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from registered state only, so data holds steady while stalled.
    always_comb begin
        out_valid = 1'b0;
        out_data  = 8'h00;
        busy      = 1'b1;
        done      = 1'b0;
        case (state_r)
            ST_IDLE: busy = 1'b0;
            ST_SEND: begin
                out_valid = 1'b1;
                out_data  = cur_byte_s;
            end
            ST_CSUM: begin
`ifdef REG_DUMP_CHECKSUM_EN
                out_valid = 1'b1;
                out_data  = csum_r;
`else
                busy      = 1'b0;
`endif
            end
            ST_FIN:  done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_reg_dump_tx.sv
// Randomized scoreboard bench for reg_dump_tx; expected bytes come from a register-array model.
module tb_reg_dump_tx;

    localparam int DW  = 32;
    localparam int NR  = 32;
    localparam int W   = DW * NR;
    localparam int TBY = NR * DW / 8;
`ifdef REG_DUMP_CHECKSUM_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         out_ready;
    logic         out_valid;
    logic [7:0]   out_data;
    logic         busy;
    logic         done;
    logic [W-1:0] registers;

    reg_dump_tx #(.DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
        .clk(clk), .reset(reset), .registers(registers), .start(start),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] regs [NR];
    logic [7:0]  exp_q [$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          done_count = 0;
    int          done_cyc = 0;
    logic        hold_pend = 1'b0;
    logic [7:0]  hold_data = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expected byte per accepted transfer and checks handshake stability.
    always @(negedge clk) begin
        if (reset) begin
            hold_pend = 1'b0;
        end else begin
            if (out_valid) begin
                if (hold_pend) chk("hold_stable", {24'h0, out_data}, {24'h0, hold_data});
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL extra_byte: got 0x%0h, expected no byte (cycle %0d)", out_data, cyc);
                    end else begin
                        chk("byte", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
                    end
                    hold_pend = 1'b0;
                end else begin
                    hold_pend = 1'b1;
                    hold_data = out_data;
                end
            end else if (hold_pend) begin
                n_chk++;
                n_fail++;
                $display("FAIL valid_drop: got out_valid 0, expected 1 until transfer (cycle %0d)", cyc);
                hold_pend = 1'b0;
            end
            if (done) begin
                done_count++;
                done_cyc = cyc;
            end
        end
    end

    // Drive the bus from the model array and queue the bytes a dump of it must produce.
    task automatic load_and_queue();
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h00;
        for (int r = 0; r < NR; r++) begin
            registers[W-1-DW*r -: DW] = regs[r];
            for (int k = 3; k >= 0; k--) begin
                b = regs[r][8*k +: 8];
                exp_q.push_back(b);
                x = x ^ b;
            end
        end
`ifdef REG_DUMP_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    task automatic rand_regs();
        for (int r = 0; r < NR; r++) regs[r] = $urandom;
    endtask

    task automatic zero_regs();
        for (int r = 0; r < NR; r++) regs[r] = 32'h0;
    endtask

    // mode 0: ready high, 1: stall 3 cycles on byte 5, 2: random ready,
    // 3: bus changes after start, 4: extra start mid-dump. exp_delta < 0 skips done timing.
    task automatic run_dump(input int mode, input int exp_delta);
        int n0;
        int dc0;
        load_and_queue();
        out_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        start = 1'b1;
        n0  = cyc + 1;
        dc0 = done_count;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk); #1;
        chk("busy_after_start", {31'h0, busy}, 32'h1);
        chk("valid_after_start", {31'h0, out_valid}, 32'h1);
        for (int k = 0; k < 3000 && done_count == dc0; k++) begin
            @(posedge clk); #1;
            case (mode)
                1:       out_ready = !(cyc >= n0 + 5 && cyc <= n0 + 7);
                2:       out_ready = 1'($urandom_range(0, 1));
                3:       if (cyc == n0 + 1) registers = '1;
                4:       start = (cyc == n0 + 40);
                default: out_ready = 1'b1;
            endcase
            @(negedge clk); #1;
        end
        start = 1'b0;
        out_ready = 1'b1;
        chk("done_seen", done_count - dc0, 32'd1);
        if (exp_delta >= 0) chk("done_cycle", done_cyc - n0, exp_delta);
        chk("queue_empty", exp_q.size(), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        @(negedge clk); #1;
        chk("busy_after_done", {31'h0, busy}, 32'h0);
        chk("done_pulse_len", {31'h0, done}, 32'h0);
        chk("idle_valid", {31'h0, out_valid}, 32'h0);
    endtask

    task automatic reset_mid_dump();
        int n0;
        int dc0;
        rand_regs();
        load_and_queue();
        out_ready = 1'b1;
        start = 1'b1;
        n0 = cyc + 1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 50 && cyc < n0 + 10; k++) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        exp_q.delete();
        dc0 = done_count;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk); #1;
        chk("rst_mid_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_mid_busy", {31'h0, busy}, 32'h0);
        chk("rst_mid_done", {31'h0, done}, 32'h0);
        chk("rst_mid_data", {24'h0, out_data}, 32'h0);
        repeat (5) @(negedge clk);
        #1;
        chk("rst_mid_no_done", done_count - dc0, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b1;
        out_ready = 1'b1;
        registers = '0;
        zero_regs();
        repeat (3) begin
            @(posedge clk);
            @(negedge clk); #1;
            chk("rst_valid", {31'h0, out_valid}, 32'h0);
            chk("rst_busy", {31'h0, busy}, 32'h0);
            chk("rst_done", {31'h0, done}, 32'h0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        repeat (3) begin
            @(negedge clk); #1;
            chk("post_rst_idle", {31'h0, out_valid}, 32'h0);
        end

        zero_regs();
        regs[0] = 32'h11223344;
        run_dump(0, TBY + EXTRA);

        rand_regs();
        run_dump(1, TBY + 3 + EXTRA);

        rand_regs();
        run_dump(3, TBY + EXTRA);

        rand_regs();
        run_dump(4, TBY + EXTRA);

        reset_mid_dump();
        rand_regs();
        run_dump(0, TBY + EXTRA);

        zero_regs();
        regs[1] = 32'h01020304;
        run_dump(0, TBY + EXTRA);

        repeat (3) begin
            rand_regs();
            run_dump(2, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
